// File: rtl/bitstream_frame_rx.sv
// Serial frame receiver: collects an LSB-first header, decodes and validates
// the command, hands it to the PMU over a valid/ready handshake, then streams
// the payload bits out one cycle after sampling, flagging block boundaries.
module bitstream_frame_rx #(
  parameter int HEADER_WIDTH   = 64,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int BLOCK_WIDTH    = 128,
  parameter int MEM_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      data_i,
  output logic                      rx_ready_o,
  output logic [3:0]                cmd_o,
  output logic [31:0]               len_o,
  output logic [MEM_ADDR_WIDTH-1:0] addr_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic                      pay_valid_o,
  output logic                      pay_bit_o,
  output logic                      blk_end_o,
  output logic                      frame_done_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o
);

  // Low header field = opcode + address; the length field is the top 32 bits.
  localparam int          LO_W     = 4 + MEM_ADDR_WIDTH;
  localparam logic [31:0] LO_W32   = 32'(LO_W);
  localparam logic [31:0] HDR_LAST = 32'(HEADER_WIDTH - 1);
  localparam logic [31:0] BLK_W32  = 32'(BLOCK_WIDTH);
  localparam logic [31:0] MDW32    = 32'(MEM_DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, HDR, CMD, PAYLOAD, ERR} state_t;

  state_t state, state_nxt;

  // Only the fields that are decoded are kept; ignored header bits fall
  // straight through. The top length bit is taken from data_i at decode.
  logic [LO_W-1:0]  lo_sr;
  logic [30:0]      len_sr;
  logic [31:0]      cnt;

  logic [3:0]                dec_cmd;
  logic [MEM_ADDR_WIDTH-1:0] dec_addr;
  logic [31:0]               dec_len;
  logic                      hdr_last;
  logic                      pay_last;
  logic                      blk_hit;

  function automatic logic op_ok_f(input logic [3:0] op);
    return (op == 4'b1010) || (op == 4'b0001) || (op == 4'b0010);
  endfunction

  function automatic logic len_ok_f(input logic [3:0] op, input logic [31:0] len);
    case (op)
      4'b0001: return (len % MDW32) == 32'd0;
      4'b0010: return len == BLK_W32;
      default: return 1'b1;
    endcase
  endfunction

  assign dec_cmd  = lo_sr[3:0];
  assign dec_addr = lo_sr[LO_W-1:4];
  assign dec_len  = {data_i, len_sr};
  assign hdr_last = (cnt == HDR_LAST);
  // cnt never exceeds len_o-1 in PAYLOAD, so cnt+1 cannot wrap even at 2^32-1.
  assign pay_last = (cnt == len_o - 32'd1);
  assign blk_hit  = ((cnt + 32'd1) % BLK_W32) == 32'd0;

  assign rx_ready_o = (state == IDLE) || (state == HDR) || (state == PAYLOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = HDR;
      HDR: begin
        if (!en)          state_nxt = ERR;
        else if (hdr_last) state_nxt = (op_ok_f(dec_cmd) && len_ok_f(dec_cmd, dec_len)) ? CMD : ERR;
      end
      CMD:     if (cmd_ready_i) state_nxt = (len_o == 32'd0) ? IDLE : PAYLOAD;
      PAYLOAD: begin
        if (!en)          state_nxt = ERR;
        else if (pay_last) state_nxt = IDLE;
      end
      ERR:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Header capture, command/error registers, counter and payload output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_sr        <= '0;
      len_sr       <= '0;
      cnt          <= '0;
      cmd_o        <= '0;
      len_o        <= '0;
      addr_o       <= '0;
      cmd_valid_o  <= 1'b0;
      pay_valid_o  <= 1'b0;
      pay_bit_o    <= 1'b0;
      blk_end_o    <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= 2'b00;
    end else begin
      pay_valid_o  <= 1'b0;
      blk_end_o    <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            lo_sr      <= {data_i, lo_sr[LO_W-1:1]};
            len_sr     <= {data_i, len_sr[30:1]};
            cnt        <= 32'd1;
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
          end
        end
        HDR: begin
          if (!en) begin
            err_o      <= 1'b1;
            err_code_o <= 2'b10;
          end else begin
            if (cnt < LO_W32) lo_sr <= {data_i, lo_sr[LO_W-1:1]};
            len_sr <= {data_i, len_sr[30:1]};
            cnt    <= cnt + 32'd1;
            if (hdr_last) begin
              if (!op_ok_f(dec_cmd)) begin
                err_o      <= 1'b1;
                err_code_o <= 2'b01;
              end else if (!len_ok_f(dec_cmd, dec_len)) begin
                err_o      <= 1'b1;
                err_code_o <= 2'b11;
              end else begin
                cmd_o       <= dec_cmd;
                addr_o      <= dec_addr;
                len_o       <= dec_len;
                cmd_valid_o <= 1'b1;
              end
            end
          end
        end
        CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cnt         <= 32'd0;
            if (len_o == 32'd0) frame_done_o <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (!en) begin
            err_o      <= 1'b1;
            err_code_o <= 2'b10;
          end else begin
            pay_valid_o <= 1'b1;
            pay_bit_o   <= data_i;
            blk_end_o   <= blk_hit || pay_last;
            cnt         <= cnt + 32'd1;
            if (pay_last) frame_done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_frame_rx.sv
// Testbench for bitstream_frame_rx: directed scenarios plus randomized frames,
// checked against an expectation queue built from the frame description.
module tb_bitstream_frame_rx;

  localparam int BW = 128;

  logic        clk = 1'b0;
  logic        rst, en, data_i, cmd_ready_i;
  logic        rx_ready_o, cmd_valid_o, pay_valid_o, pay_bit_o, blk_end_o;
  logic        frame_done_o, err_o;
  logic [3:0]  cmd_o;
  logic [31:0] len_o;
  logic [7:0]  addr_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  bitstream_frame_rx dut (
    .clk(clk), .rst(rst), .en(en), .data_i(data_i), .rx_ready_o(rx_ready_o),
    .cmd_o(cmd_o), .len_o(len_o), .addr_o(addr_o), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .pay_valid_o(pay_valid_o), .pay_bit_o(pay_bit_o),
    .blk_end_o(blk_end_o), .frame_done_o(frame_done_o), .err_o(err_o),
    .err_code_o(err_code_o)
  );

  typedef struct packed {logic b; logic blk; logic done;} beat_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       exp_q[$];
  int          blk_pos[$];
  int          pay_cnt, blk_cnt, cmdv_cnt;
  bit          zero_pending = 1'b0;
  logic [3:0]  exp_cmd = '0;
  logic [31:0] exp_len = '0;
  logic [7:0]  exp_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Outputs settle 1 time unit after each edge; the monitor looks first,
  // the driver at +2 then checks and sets up the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [1:0] exp_code(input logic [3:0] op, input logic [31:0] len);
    if (!(op == 4'b1010 || op == 4'b0001 || op == 4'b0010)) return 2'b01;
    if (op == 4'b0001 && (len % 32) != 0) return 2'b11;
    if (op == 4'b0010 && len != 32'd128) return 2'b11;
    return 2'b00;
  endfunction

  // Per-cycle compare against the expectation queue.
  always @(posedge clk) begin
    beat_t e;
    bit    ev;
    #1;
    ev = (exp_q.size() > 0);
    e  = '0;
    if (ev) e = exp_q.pop_front();
    chk("pay_valid", pay_valid_o, ev);
    chk("frame_done", frame_done_o, ev ? e.done : zero_pending);
    zero_pending = 1'b0;
    chk("blk_end", blk_end_o, ev ? e.blk : 1'b0);
    if (ev && pay_valid_o) chk("pay_bit", pay_bit_o, e.b);
    if (pay_valid_o) begin
      if (blk_end_o) begin
        blk_pos.push_back(pay_cnt);
        blk_cnt++;
      end
      pay_cnt++;
    end
    if (cmd_valid_o) begin
      cmdv_cnt++;
      chk("cmd_fields", {cmd_o, len_o, addr_o}, {exp_cmd, exp_len, exp_addr});
    end
  end

  task automatic run_frame(input logic [3:0] op, input logic [31:0] len, input logic [7:0] addr,
                           input int dly, input int abort_hdr, input int abort_pay, input int rst_pay);
    logic [63:0] hdr;
    logic [1:0]  code;
    hdr = {len, 20'($urandom), addr, op};
    code = exp_code(op, len);
    pay_cnt = 0; blk_cnt = 0; cmdv_cnt = 0;
    blk_pos.delete();
    exp_cmd = op; exp_len = len; exp_addr = addr;
    for (int i = 0; i < 64; i++) begin
      chk("rx_ready_hdr", rx_ready_o, 1'b1);
      if (i == abort_hdr) begin
        en = 1'b0;
        step();
        chk("abort_hdr_err", {err_o, err_code_o, rx_ready_o, cmd_valid_o}, {1'b1, 2'b10, 1'b0, 1'b0});
        step();
        chk("abort_hdr_idle", {rx_ready_o, err_code_o}, {1'b1, 2'b10});
        return;
      end
      en = 1'b1;
      data_i = hdr[i];
      cmd_ready_i = (dly == 0);
      step();
      if (i == 0) chk("err_clear", {err_o, err_code_o}, 3'b000);
    end
    if (code != 2'b00) begin
      chk("dec_err", {err_o, err_code_o, cmd_valid_o, rx_ready_o}, {1'b1, code, 1'b0, 1'b0});
      en = 1'b1; data_i = 1'($urandom);
      step();
      chk("err_hold", {err_o, err_code_o, rx_ready_o}, {1'b1, code, 1'b0});
      en = 1'b0;
      step();
      chk("err_exit", {rx_ready_o, err_code_o}, {1'b1, code});
      return;
    end
    chk("cmd_valid_up", {cmd_valid_o, rx_ready_o}, 2'b10);
    for (int d = 0; d < dly; d++) begin
      cmd_ready_i = 1'b0;
      en = 1'($urandom);
      step();
      chk("cmd_valid_hold", {cmd_valid_o, rx_ready_o}, 2'b10);
    end
    cmd_ready_i = 1'b1;
    en = 1'($urandom);
    zero_pending = (len == 32'd0);
    step();
    cmd_ready_i = 1'b0;
    chk("cmd_valid_cycles", cmdv_cnt, dly + 1);
    chk("cmd_valid_down", {cmd_valid_o, rx_ready_o}, 2'b01);
    if (len == 32'd0) begin
      en = 1'b0;
      step();
      return;
    end
    for (int j = 0; j < int'(len); j++) begin
      if (j == rst_pay) begin
        rst = 1'b1; en = 1'b1; data_i = 1'($urandom);
        step();
        rst = 1'b0;
        chk("rst_outputs", {cmd_o, len_o, addr_o, cmd_valid_o, pay_valid_o, pay_bit_o,
                            blk_end_o, frame_done_o, err_o, err_code_o}, 64'd0);
        chk("rst_rx_ready", rx_ready_o, 1'b1);
        en = 1'b0;
        step();
        return;
      end
      if (j == abort_pay) begin
        en = 1'b0;
        step();
        chk("abort_pay_err", {err_o, err_code_o, rx_ready_o}, {1'b1, 2'b10, 1'b0});
        step();
        chk("abort_pay_idle", {rx_ready_o, err_code_o}, {1'b1, 2'b10});
        chk("abort_pay_count", pay_cnt, j);
        return;
      end
      en = 1'b1;
      data_i = 1'($urandom);
      exp_q.push_back(beat_t'{data_i, (((j + 1) % BW) == 0) || (j == int'(len) - 1),
                               j == int'(len) - 1});
      step();
      chk("rx_ready_pay", rx_ready_o, 1'b1);
    end
    en = 1'b0;
    step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("pay_count", pay_cnt, len);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, p2, r, ah, ap, dl;
    logic [3:0]  op;
    logic [31:0] ln;
    rst = 1'b1; en = 1'b0; data_i = 1'b0; cmd_ready_i = 1'b0;
    step();
    step();
    chk("reset_outputs", {cmd_o, len_o, addr_o, cmd_valid_o, pay_valid_o, pay_bit_o,
                          blk_end_o, frame_done_o, err_o, err_code_o}, 64'd0);
    chk("reset_rx_ready", rx_ready_o, 1'b1);
    rst = 1'b0;
    step();

    // Key load.
    run_frame(4'b0010, 32'd128, 8'hA7, 0, -1, -1, -1);
    p0 = (blk_pos.size() > 0) ? blk_pos[0] : -1;
    chk("keyload_pay_cnt", pay_cnt, 128);
    chk("keyload_blk_cnt", blk_cnt, 1);
    chk("keyload_blk_pos", p0, 127);

    // PC to MEM with a delayed handshake.
    run_frame(4'b0001, 32'd64, 8'h05, 5, -1, -1, -1);
    p0 = (blk_pos.size() > 0) ? blk_pos[0] : -1;
    chk("mem_cmdv_cycles", cmdv_cnt, 6);
    chk("mem_pay_cnt", pay_cnt, 64);
    chk("mem_blk_pos", p0, 63);

    // Bad opcode.
    run_frame(4'b0111, 32'd16, 8'h33, 0, -1, -1, -1);
    chk("badop_code", err_code_o, 2'b01);
    chk("badop_no_cmd", cmdv_cnt, 0);

    // Header abort after bit 30, then failed length check.
    run_frame(4'b1010, 32'd100, 8'h11, 0, 31, -1, -1);
    chk("abort_code", err_code_o, 2'b10);
    run_frame(4'b0001, 32'd40, 8'h22, 0, -1, -1, -1);
    chk("lencheck_code", err_code_o, 2'b11);

    // PC to SC, zero length.
    run_frame(4'b1010, 32'd0, 8'h44, 2, -1, -1, -1);
    chk("zero_len_pay_cnt", pay_cnt, 0);

    // Long payload with block boundaries, then reset mid-payload.
    run_frame(4'b1010, 32'd300, 8'h55, 1, -1, -1, -1);
    p0 = (blk_pos.size() > 0) ? blk_pos[0] : -1;
    p1 = (blk_pos.size() > 1) ? blk_pos[1] : -1;
    p2 = (blk_pos.size() > 2) ? blk_pos[2] : -1;
    chk("long_blk_cnt", blk_cnt, 3);
    chk("long_blk_pos", {p0[15:0], p1[15:0], p2[15:0]}, {16'd127, 16'd255, 16'd299});
    run_frame(4'b1010, 32'd300, 8'h66, 0, -1, -1, 200);
    chk("rst_pay_cnt", pay_cnt, 200);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        op = 4'b1010; ln = 32'($urandom_range(0, 300));
      end else if (r <= 6) begin
        op = 4'b0001;
        ln = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 200)) : 32'(32 * $urandom_range(0, 8));
      end else if (r <= 8) begin
        op = 4'b0010;
        ln = ($urandom_range(0, 3) == 0) ? 32'd40 : 32'd128;
      end else begin
        op = 4'($urandom);
        while (op == 4'b1010 || op == 4'b0001 || op == 4'b0010) op = 4'($urandom);
        ln = 32'($urandom_range(0, 300));
      end
      dl = $urandom_range(0, 6);
      ah = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 63) : -1;
      ap = (ah < 0 && ln > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, int'(ln) - 1) : -1;
      run_frame(op, ln, 8'($urandom), dl, ah, ap, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
